// File: rtl/alu_arb_pkg.sv
// Shared ALU op codes and the two-way arbitration helper used by alu_arb.
// The external ALU decodes the same alu_op_e codes.
package alu_arb_pkg;

  localparam int ALU_OP_W = 4;
  localparam int N_REQ    = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_ADDU = 4'd11,
    ALU_SUBU = 4'd12
  } alu_op_e;

  // One-hot grant {g1, g0}; ptr only matters when both requesters are eligible.
  function automatic logic [1:0] arb_pick(input logic e0, input logic e1, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (e0 && e1) begin
      g = ptr ? 2'b10 : 2'b01;
    end else if (e0) begin
      g = 2'b01;
    end else if (e1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_arb_rsp_buf.sv
// Single-entry result register with valid/ready; a load on the same edge as a
// drain refills the entry so a requester can sustain one result per cycle.
module alu_arb_rsp_buf
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_zero,
  input  logic              i_gez,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_zero,
  output logic              o_gez
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_zero;
  logic              r_gez;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_gez   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_zero  <= i_zero;
      r_gez   <= i_gez;
    end else if (i_ready) begin
      // payload is left untouched on drain; only valid drops
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_zero  = r_zero;
  assign o_gez   = r_gez;

endmodule

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared, external combinational ALU.
// Grants at most one requester per cycle and buffers each requester's result.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [OP_W-1:0]   i_req0_op,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [OP_W-1:0]   i_req1_op,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_c,
  input  logic              i_alu_zero,
  input  logic              i_alu_gez,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp0_zero,
  output logic              o_rsp0_gez,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic              o_rsp1_zero,
  output logic              o_rsp1_gez,
  output logic [CNT_W-1:0]  o_grant_cnt
);

  logic [N_REQ-1:0]  w_req_valid;
  logic [N_REQ-1:0]  w_rsp_valid;
  logic [N_REQ-1:0]  w_rsp_ready;
  logic [N_REQ-1:0]  w_rsp_zero;
  logic [N_REQ-1:0]  w_rsp_gez;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic [DATA_W-1:0] w_rsp_data [N_REQ];

  logic              r_ptr;
  logic [CNT_W-1:0]  r_grant_cnt;

  assign w_req_valid = {i_req1_valid, i_req0_valid};
  assign w_rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // A requester may go only if its result slot is empty or draining this cycle.
  assign w_elig  = w_req_valid & (~w_rsp_valid | w_rsp_ready);
  assign w_grant = rst_n ? arb_pick(w_elig[0], w_elig[1], r_ptr) : 2'b00;

  assign o_req0_ready = w_grant[0];
  assign o_req1_ready = w_grant[1];

  always_comb begin
    o_alu_op = OP_W'(ALU_ADD);
    o_alu_a  = '0;
    o_alu_b  = '0;
    if (w_grant[0]) begin
      o_alu_op = i_req0_op;
      o_alu_a  = i_req0_a;
      o_alu_b  = i_req0_b;
    end else if (w_grant[1]) begin
      o_alu_op = i_req1_op;
      o_alu_a  = i_req1_a;
      o_alu_b  = i_req1_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_grant_cnt <= '0;
    end else begin
      if (w_grant[0]) begin
        r_ptr <= 1'b1;
      end else if (w_grant[1]) begin
        r_ptr <= 1'b0;
      end
      if (|w_grant) begin
        r_grant_cnt <= r_grant_cnt + 1'b1;
      end
    end
  end

  assign o_grant_cnt = r_grant_cnt;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      alu_arb_rsp_buf #(
        .DATA_W (DATA_W)
      ) u_rsp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_grant[gi]),
        .i_data  (i_alu_c),
        .i_zero  (i_alu_zero),
        .i_gez   (i_alu_gez),
        .i_ready (w_rsp_ready[gi]),
        .o_valid (w_rsp_valid[gi]),
        .o_data  (w_rsp_data[gi]),
        .o_zero  (w_rsp_zero[gi]),
        .o_gez   (w_rsp_gez[gi])
      );
    end
  endgenerate

  assign o_rsp0_valid = w_rsp_valid[0];
  assign o_rsp0_data  = w_rsp_data[0];
  assign o_rsp0_zero  = w_rsp_zero[0];
  assign o_rsp0_gez   = w_rsp_gez[0];
  assign o_rsp1_valid = w_rsp_valid[1];
  assign o_rsp1_data  = w_rsp_data[1];
  assign o_rsp1_zero  = w_rsp_zero[1];
  assign o_rsp1_gez   = w_rsp_gez[1];

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: provides the external ALU and checks every cycle against
// a transaction-level model of arbitration, result buffering and grant count.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [3:0]  req_op    [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        alu_zero, alu_gez;
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_zero  [2];
  logic        rsp_gez   [2];
  logic [15:0] grant_cnt;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int          m_ptr;
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  bit          m_rz [2];
  bit          m_rg [2];
  int unsigned m_cnt;
  int          last_grant;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req0_valid (req_valid[0]),
    .o_req0_ready (req_ready[0]),
    .i_req0_op    (req_op[0]),
    .i_req0_a     (req_a[0]),
    .i_req0_b     (req_b[0]),
    .i_req1_valid (req_valid[1]),
    .o_req1_ready (req_ready[1]),
    .i_req1_op    (req_op[1]),
    .i_req1_a     (req_a[1]),
    .i_req1_b     (req_b[1]),
    .o_alu_op     (alu_op),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .i_alu_c      (alu_c),
    .i_alu_zero   (alu_zero),
    .i_alu_gez    (alu_gez),
    .o_rsp0_valid (rsp_valid[0]),
    .i_rsp0_ready (rsp_ready[0]),
    .o_rsp0_data  (rsp_data[0]),
    .o_rsp0_zero  (rsp_zero[0]),
    .o_rsp0_gez   (rsp_gez[0]),
    .o_rsp1_valid (rsp_valid[1]),
    .i_rsp1_ready (rsp_ready[1]),
    .o_rsp1_data  (rsp_data[1]),
    .o_rsp1_zero  (rsp_zero[1]),
    .o_rsp1_gez   (rsp_gez[1]),
    .o_grant_cnt  (grant_cnt)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      ALU_ADD, ALU_ADDU: return a + b;
      ALU_SUB, ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  // the external ALU
  always_comb begin
    alu_c    = alu_fn(alu_op, alu_a, alu_b);
    alu_zero = (alu_c == 32'd0);
    alu_gez  = ~alu_c[31];
  end

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    last_grant = -1;
    for (int n = 0; n < 2; n++) begin
      m_rv[n] = 0; m_rd[n] = '0; m_rz[n] = 0; m_rg[n] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 1'b0; req_op[n] = '0; req_a[n] = '0; req_b[n] = '0;
      rsp_ready[n] = 1'b1;
    end
  endtask

  // Called at a falling edge with inputs already set; advances one clock.
  task automatic tick();
    int g;
    bit e [2];
    logic [31:0] exp_c;
    #1;
    for (int n = 0; n < 2; n++) e[n] = req_valid[n] && (!m_rv[n] || rsp_ready[n]);
    g = -1;
    if (e[0] && e[1]) g = m_ptr;
    else if (e[0]) g = 0;
    else if (e[1]) g = 1;
    last_grant = g;
    for (int n = 0; n < 2; n++) begin
      vectors++;
      if (req_ready[n] !== (g == n)) begin
        miscompares++;
        $display("FAIL req%0d_ready: got %0b want %0b", n, req_ready[n], (g == n));
      end
    end
    vectors++;
    if (g < 0) begin
      if (alu_op !== ALU_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
        miscompares++;
        $display("FAIL alu_idle: got op=%0d a=%h b=%h want ADD,0,0", alu_op, alu_a, alu_b);
      end
    end else if (alu_op !== req_op[g] || alu_a !== req_a[g] || alu_b !== req_b[g]) begin
      miscompares++;
      $display("FAIL alu_drive: got op=%0d a=%h b=%h want op=%0d a=%h b=%h",
               alu_op, alu_a, alu_b, req_op[g], req_a[g], req_b[g]);
    end
    exp_c = (g >= 0) ? alu_fn(req_op[g], req_a[g], req_b[g]) : 32'd0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (g == n) begin
        m_rv[n] = 1; m_rd[n] = exp_c; m_rz[n] = (exp_c == 0); m_rg[n] = !exp_c[31];
      end else if (rsp_ready[n]) begin
        m_rv[n] = 0;
      end
    end
    if (g >= 0) begin
      m_ptr = 1 - g;
      m_cnt = (m_cnt + 1) & 32'hFFFF;
    end
    for (int n = 0; n < 2; n++) begin
      vectors++;
      if (rsp_valid[n] !== m_rv[n] || rsp_data[n] !== m_rd[n] ||
          rsp_zero[n] !== m_rz[n] || rsp_gez[n] !== m_rg[n]) begin
        miscompares++;
        $display("FAIL rsp%0d: got v=%0b d=%h z=%0b g=%0b want v=%0b d=%h z=%0b g=%0b", n,
                 rsp_valid[n], rsp_data[n], rsp_zero[n], rsp_gez[n],
                 m_rv[n], m_rd[n], m_rz[n], m_rg[n]);
      end
    end
    vectors++;
    if (grant_cnt !== m_cnt[15:0]) begin
      miscompares++;
      $display("FAIL grant_cnt: got %0d want %0d", grant_cnt, m_cnt);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    model_reset();
    #1;
    for (int n = 0; n < 2; n++) begin
      vectors++;
      if (req_ready[n] !== 1'b0 || rsp_valid[n] !== 1'b0 || rsp_data[n] !== 32'd0 ||
          rsp_zero[n] !== 1'b0 || rsp_gez[n] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state%0d: got rdy=%0b v=%0b d=%h z=%0b g=%0b want all 0", n,
                 req_ready[n], rsp_valid[n], rsp_data[n], rsp_zero[n], rsp_gez[n]);
      end
    end
    vectors++;
    if (grant_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d want 0", grant_cnt);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    do_reset();
    req_valid[0] = 1'b1; req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    tick();
    req_valid[0] = 1'b0;
    vectors++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'd12 || rsp_zero[0] !== 1'b0 ||
        rsp_gez[0] !== 1'b1 || grant_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL single_add: got v=%0b d=%0d z=%0b g=%0b cnt=%0d want 1,12,0,1,1",
               rsp_valid[0], rsp_data[0], rsp_zero[0], rsp_gez[0], grant_cnt);
    end
    tick();
    $display("test_single_add: rsp0_data=%0d grant_cnt=%0d", rsp_data[0], grant_cnt);
  endtask

  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int n = 0; n < 2; n++) begin
        req_valid[n] = 1'b1; req_op[n] = ALU_XOR; req_a[n] = $urandom; req_b[n] = $urandom;
      end
      #1;
      vectors++;
      if (req_ready[k % 2] !== 1'b1 || req_ready[1 - k % 2] !== 1'b0) begin
        miscompares++;
        $display("FAIL alternate_grant k=%0d: got rdy0=%0b rdy1=%0b want grant to %0d",
                 k, req_ready[0], req_ready[1], k % 2);
      end
      tick();
      vectors++;
      if (rsp_valid[k % 2] !== 1'b1 || rsp_valid[1 - k % 2] !== 1'b0) begin
        miscompares++;
        $display("FAIL alternate_rsp k=%0d: got v0=%0b v1=%0b want only rsp%0d", k,
                 rsp_valid[0], rsp_valid[1], k % 2);
      end
    end
    idle_inputs();
    tick();
    $display("test_alternate done");
  endtask

  task automatic test_stall();
    do_reset();
    req_valid[0] = 1'b1; req_op[0] = ALU_SUB; req_a[0] = 32'd3; req_b[0] = 32'd3;
    rsp_ready[0] = 1'b0;
    req_valid[1] = 1'b1; req_op[1] = ALU_ADD; req_a[1] = 32'd10; req_b[1] = 32'd1;
    tick();
    for (int k = 0; k < 4; k++) begin
      req_a[1] = $urandom;
      #1;
      vectors++;
      if (req_ready[0] !== 1'b0 || req_ready[1] !== 1'b1 || rsp_valid[0] !== 1'b1 ||
          rsp_data[0] !== 32'd0 || rsp_zero[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL stall k=%0d: got rdy0=%0b rdy1=%0b v0=%0b d0=%h z0=%0b want 0,1,1,0,1",
                 k, req_ready[0], req_ready[1], rsp_valid[0], rsp_data[0], rsp_zero[0]);
      end
      tick();
    end
    rsp_ready[0] = 1'b1;
    req_a[0] = 32'd9;
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got req0_ready=%0b want 1", req_ready[0]);
    end
    tick();
    idle_inputs();
    tick();
    $display("test_stall done");
  endtask

  task automatic test_sub_neg();
    do_reset();
    req_valid[1] = 1'b1; req_op[1] = ALU_SUB; req_a[1] = 32'd1; req_b[1] = 32'd2;
    tick();
    idle_inputs();
    vectors++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'hFFFF_FFFF || rsp_gez[1] !== 1'b0 ||
        rsp_zero[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_neg: got v=%0b d=%h z=%0b g=%0b want 1,ffffffff,0,0",
               rsp_valid[1], rsp_data[1], rsp_zero[1], rsp_gez[1]);
    end
    tick();
    $display("test_sub_neg: rsp1_data=%h", rsp_data[1]);
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++) begin
        req_valid[n] = ($urandom_range(0, 3) != 0);
        req_op[n]    = 4'($urandom_range(0, 12));
        req_a[n]     = $urandom;
        req_b[n]     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
        rsp_ready[n] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    idle_inputs();
    tick();
    $display("test_random: grant_cnt=%0d", grant_cnt);
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    req_valid[0] = 1'b1; req_op[0] = ALU_OR;
    budget = 70000;
    while (m_cnt != 65535 && budget > 0) begin
      req_a[0] = $urandom;
      req_b[0] = $urandom;
      tick();
      budget--;
    end
    vectors++;
    if (grant_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_full: got %h want ffff", grant_cnt);
    end
    tick();
    vectors++;
    if (grant_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_zero: got %h want 0000", grant_cnt);
    end
    idle_inputs();
    tick();
    $display("test_wrap: grant_cnt=%h", grant_cnt);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid[0] = 1'b1; req_op[0] = ALU_AND; req_a[0] = 32'hF0F0; req_b[0] = 32'hFF00;
    rsp_ready[0] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'd0 || grant_cnt !== 16'd0 ||
        req_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got v0=%0b d0=%h cnt=%0d rdy0=%0b want 0,0,0,0",
               rsp_valid[0], rsp_data[0], grant_cnt, req_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 1'b1; req_op[n] = ALU_SLT; req_a[n] = $urandom; req_b[n] = $urandom;
    end
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ptr: got rdy0=%0b rdy1=%0b want 1,0", req_ready[0], req_ready[1]);
    end
    tick();
    idle_inputs();
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_add();
    test_alternate();
    test_stall();
    test_sub_neg();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
